// File: rtl/matrix_uart_sequencer.sv
// Sequences UART RX bytes into a matrix buffer, starts the accelerator once a
// full frame is loaded, and latches the accelerator result onto the GPIO pads.
module matrix_uart_sequencer #(
    parameter int N_ELEM   = 4,
    parameter int IDLE_TMO = 1024,
    parameter int ACC_TMO  = 4096
) (
    input  logic                      sys_clk_i,
    input  logic                      rst_n,
    input  logic                      rx_valid_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_err_i,
    output logic                      mat_we_o,
    output logic [$clog2(N_ELEM)-1:0] mat_addr_o,
    output logic [7:0]                mat_wdata_o,
    output logic                      acc_start_o,
    input  logic                      acc_done_i,
    input  logic [31:0]               acc_result_i,
    output logic [31:0]               gpio_o,
    output logic                      gpio_oe_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [7:0]                drop_cnt_o,
    output logic [1:0]                dbg_state_o
);
    localparam int AW    = $clog2(N_ELEM);
    localparam int TMAX  = (ACC_TMO > IDLE_TMO) ? ACC_TMO : IDLE_TMO;
    localparam int TW    = $clog2(TMAX) + 1;
    localparam logic [AW-1:0] LAST      = AW'(N_ELEM - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TMO - 1);
    localparam logic [TW-1:0] ACC_LAST  = TW'(ACC_TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] count;
    logic [TW-1:0] timer;
    logic          rx_ok;
    logic          rx_bad;

    assign rx_ok       = rx_valid_i & ~rx_err_i;
    assign rx_bad      = rx_valid_i & rx_err_i;
    assign dbg_state_o = state;

    always_ff @(posedge sys_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            timer       <= '0;
            mat_we_o    <= 1'b0;
            mat_addr_o  <= '0;
            mat_wdata_o <= '0;
            acc_start_o <= 1'b0;
            gpio_o      <= '0;
            gpio_oe_o   <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            drop_cnt_o  <= '0;
        end else begin
            mat_we_o    <= 1'b0;
            acc_start_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_ok) begin
                        mat_we_o    <= 1'b1;
                        mat_addr_o  <= '0;
                        mat_wdata_o <= rx_data_i;
                        count       <= AW'(1);
                        timer       <= '0;
                        err_o       <= 1'b0;
                        state       <= S_LOAD;
                        busy_o      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (rx_ok) begin
                        mat_we_o    <= 1'b1;
                        mat_wdata_o <= rx_data_i;
                        timer       <= '0;
                        if (timer == IDLE_LAST) begin
                            // Byte lands on the expiry cycle: frame is lost, byte restarts it.
                            mat_addr_o <= '0;
                            count      <= AW'(1);
                            err_o      <= 1'b1;
                        end else begin
                            mat_addr_o <= count;
                            count      <= count + AW'(1);
                            if (count == LAST) begin
                                state <= S_START;
                            end
                        end
                    end else if (timer == IDLE_LAST) begin
                        err_o  <= 1'b1;
                        count  <= '0;
                        timer  <= '0;
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_START: begin
                    acc_start_o <= 1'b1;
                    timer       <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (acc_done_i) begin
                        gpio_o    <= acc_result_i;
                        gpio_oe_o <= 1'b1;
                        timer     <= '0;
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                    end else if (timer == ACC_LAST) begin
                        err_o  <= 1'b1;
                        timer  <= '0;
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (rx_valid_i && (state == S_START || state == S_WAIT) && drop_cnt_o != 8'hFF) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end
            // A framing error always wins over the clear on frame start.
            if (rx_bad) begin
                err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_matrix_uart_sequencer.sv
// Bench for matrix_uart_sequencer: vector table, directed corner sequences and
// randomized frames scored against a frame-level reference model.
module tb_matrix_uart_sequencer;
    localparam int N_ELEM   = 4;
    localparam int IDLE_TMO = 32;
    localparam int ACC_TMO  = 512;
    localparam int AW       = 2;
    localparam int W        = AW + 8;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = '0;
    logic        rx_err   = 1'b0;
    logic        acc_done = 1'b0;
    logic [31:0] acc_result = '0;
    logic          mat_we;
    logic [AW-1:0] mat_addr;
    logic [7:0]    mat_wdata;
    logic          acc_start;
    logic [31:0]   gpio;
    logic          gpio_oe;
    logic          busy;
    logic          err;
    logic [7:0]    drop_cnt;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic         sb_en = 1'b0;
    logic [W-1:0] exp_q[$];
    int           start_seen = 0;

    matrix_uart_sequencer #(.N_ELEM(N_ELEM), .IDLE_TMO(IDLE_TMO), .ACC_TMO(ACC_TMO)) dut (
        .sys_clk_i(sys_clk), .rst_n(rst_n),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_err_i(rx_err),
        .mat_we_o(mat_we), .mat_addr_o(mat_addr), .mat_wdata_o(mat_wdata),
        .acc_start_o(acc_start), .acc_done_i(acc_done), .acc_result_i(acc_result),
        .gpio_o(gpio), .gpio_oe_o(gpio_oe), .busy_o(busy), .err_o(err),
        .drop_cnt_o(drop_cnt), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // comparison helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // driver tasks
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0;
        acc_done = 1'b0; acc_result = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e);
        rx_valid = 1'b1; rx_data = d; rx_err = e;
        step();
        rx_valid = 1'b0; rx_err = 1'b0;
    endtask

    task automatic expect_write(input string name, input logic [AW-1:0] a, input logic [7:0] d);
        chk1({name, "_we"}, mat_we, 1'b1);
        chk({name, "_addr"}, 32'(mat_addr), 32'(a));
        chk({name, "_data"}, 32'(mat_wdata), 32'(d));
    endtask

    task automatic check_reset_values(input string name);
        chk1({name, "_we"}, mat_we, 1'b0);
        chk({name, "_addr"}, 32'(mat_addr), 32'd0);
        chk({name, "_wdata"}, 32'(mat_wdata), 32'd0);
        chk1({name, "_start"}, acc_start, 1'b0);
        chk({name, "_gpio"}, gpio, 32'd0);
        chk1({name, "_oe"}, gpio_oe, 1'b0);
        chk1({name, "_busy"}, busy, 1'b0);
        chk1({name, "_err"}, err, 1'b0);
        chk({name, "_drop"}, 32'(drop_cnt), 32'd0);
    endtask

    // scoreboard: every write must match the head of the expected queue
    always @(negedge sys_clk) begin
        if (sb_en) begin
            if (mat_we) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_write: got unexpected write addr %0d data 0x%0h, expected none", mat_addr, mat_wdata);
                end else begin
                    chk("sb_write", 32'({mat_addr, mat_wdata}), 32'(exp_q.pop_front()));
                end
            end
            if (acc_start) start_seen++;
        end
    end

    typedef struct {
        logic        rv;
        logic [7:0]  d;
        logic        re;
        logic        dn;
        logic [31:0] res;
        logic        e_we;
        logic [1:0]  e_addr;
        logic [7:0]  e_data;
        logic        e_start;
        logic        e_busy;
        logic        e_err;
        logic [31:0] e_gpio;
        logic        e_oe;
    } vec_t;

    function automatic vec_t mk(logic rv, logic [7:0] d, logic re, logic dn, logic [31:0] res,
                                logic e_we, logic [1:0] e_addr, logic [7:0] e_data, logic e_start,
                                logic e_busy, logic e_err, logic [31:0] e_gpio, logic e_oe);
        vec_t v;
        v.rv = rv; v.d = d; v.re = re; v.dn = dn; v.res = res;
        v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_start = e_start;
        v.e_busy = e_busy; v.e_err = e_err; v.e_gpio = e_gpio; v.e_oe = e_oe;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        //                rv d      re dn res            we a  data   st bz er gpio           oe
        tbl[0]  = mk(1, 8'h01, 0, 0, 32'h0,        1, 0, 8'h01, 0, 1, 0, 32'h0,        0);
        tbl[1]  = mk(1, 8'h02, 0, 0, 32'h0,        1, 1, 8'h02, 0, 1, 0, 32'h0,        0);
        tbl[2]  = mk(1, 8'h03, 0, 0, 32'h0,        1, 2, 8'h03, 0, 1, 0, 32'h0,        0);
        tbl[3]  = mk(1, 8'h04, 0, 0, 32'h0,        1, 3, 8'h04, 0, 1, 0, 32'h0,        0);
        tbl[4]  = mk(0, 8'h00, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 0, 32'h0,        0);
        tbl[5]  = mk(0, 8'h00, 0, 0, 32'h0,        0, 0, 8'h00, 0, 1, 0, 32'h0,        0);
        tbl[6]  = mk(0, 8'h00, 0, 1, 32'h0000000A, 0, 0, 8'h00, 0, 0, 0, 32'h0000000A, 1);
        tbl[7]  = mk(0, 8'h00, 0, 0, 32'h0,        0, 0, 8'h00, 0, 0, 0, 32'h0000000A, 1);
        tbl[8]  = mk(1, 8'h11, 0, 0, 32'h0,        1, 0, 8'h11, 0, 1, 0, 32'h0000000A, 1);
        tbl[9]  = mk(1, 8'h33, 1, 0, 32'h0,        0, 0, 8'h00, 0, 1, 1, 32'h0000000A, 1);
        tbl[10] = mk(1, 8'h22, 0, 0, 32'h0,        1, 1, 8'h22, 0, 1, 1, 32'h0000000A, 1);
        tbl[11] = mk(1, 8'h44, 0, 0, 32'h0,        1, 2, 8'h44, 0, 1, 1, 32'h0000000A, 1);
        tbl[12] = mk(1, 8'h55, 0, 0, 32'h0,        1, 3, 8'h55, 0, 1, 1, 32'h0000000A, 1);
        tbl[13] = mk(0, 8'h00, 0, 0, 32'h0,        0, 0, 8'h00, 1, 1, 1, 32'h0000000A, 1);
        tbl[14] = mk(0, 8'h00, 0, 0, 32'h0,        0, 0, 8'h00, 0, 1, 1, 32'h0000000A, 1);
        tbl[15] = mk(0, 8'h00, 0, 1, 32'h12345678, 0, 0, 8'h00, 0, 0, 1, 32'h12345678, 1);
        tbl[16] = mk(0, 8'h00, 0, 1, 32'h0000DEAD, 0, 0, 8'h00, 0, 0, 1, 32'h12345678, 1);
        tbl[17] = mk(1, 8'h66, 0, 0, 32'h0,        1, 0, 8'h66, 0, 1, 0, 32'h12345678, 1);

        // reset values while reset is held
        idle_inputs();
        #2;
        check_reset_values("reset");
        do_reset();
        check_reset_values("post_reset");

        // vector table: basic frame, framing error mid-frame, done outside WAIT
        for (int i = 0; i < 18; i++) begin
            rx_valid = tbl[i].rv; rx_data = tbl[i].d; rx_err = tbl[i].re;
            acc_done = tbl[i].dn; acc_result = tbl[i].res;
            step();
            chk1($sformatf("vec%0d_we", i), mat_we, tbl[i].e_we);
            if (tbl[i].e_we) begin
                chk($sformatf("vec%0d_addr", i), 32'(mat_addr), 32'(tbl[i].e_addr));
                chk($sformatf("vec%0d_data", i), 32'(mat_wdata), 32'(tbl[i].e_data));
            end
            chk1($sformatf("vec%0d_start", i), acc_start, tbl[i].e_start);
            chk1($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk1($sformatf("vec%0d_err", i), err, tbl[i].e_err);
            chk($sformatf("vec%0d_gpio", i), gpio, tbl[i].e_gpio);
            chk1($sformatf("vec%0d_oe", i), gpio_oe, tbl[i].e_oe);
        end
        idle_inputs();

        // load timeout, then a fresh frame clears the error
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (IDLE_TMO - 1) step();
        chk1("tmo_before_busy", busy, 1'b1);
        chk1("tmo_before_err", err, 1'b0);
        step();
        chk1("tmo_busy", busy, 1'b0);
        chk1("tmo_err", err, 1'b1);
        send_byte(8'h05, 1'b0);
        expect_write("tmo_b5", 2'd0, 8'h05);
        chk1("tmo_b5_err", err, 1'b0);
        send_byte(8'h06, 1'b0);
        expect_write("tmo_b6", 2'd1, 8'h06);
        send_byte(8'h07, 1'b0);
        expect_write("tmo_b7", 2'd2, 8'h07);
        send_byte(8'h08, 1'b0);
        expect_write("tmo_b8", 2'd3, 8'h08);
        step();
        chk1("tmo_start", acc_start, 1'b1);
        acc_done = 1'b1; acc_result = 32'hCAFEF00D;
        step();
        idle_inputs();
        chk("tmo_gpio", gpio, 32'hCAFEF00D);
        chk1("tmo_busy_done", busy, 1'b0);

        // accelerator timeout keeps the previous GPIO value
        for (int i = 0; i < N_ELEM; i++) send_byte(8'(i + 1), 1'b0);
        step();
        chk1("acc_tmo_start", acc_start, 1'b1);
        repeat (ACC_TMO - 1) step();
        chk1("acc_tmo_before_busy", busy, 1'b1);
        chk1("acc_tmo_before_err", err, 1'b0);
        step();
        chk1("acc_tmo_busy", busy, 1'b0);
        chk1("acc_tmo_err", err, 1'b1);
        chk("acc_tmo_gpio", gpio, 32'hCAFEF00D);
        chk1("acc_tmo_oe", gpio_oe, 1'b1);

        // byte arriving on the load-timeout cycle restarts the frame
        send_byte(8'hA0, 1'b0);
        repeat (IDLE_TMO - 1) step();
        send_byte(8'hA1, 1'b0);
        expect_write("edge_a1", 2'd0, 8'hA1);
        chk1("edge_err", err, 1'b1);
        chk1("edge_busy", busy, 1'b1);
        send_byte(8'hA2, 1'b0);
        expect_write("edge_a2", 2'd1, 8'hA2);
        send_byte(8'hA3, 1'b0);
        expect_write("edge_a3", 2'd2, 8'hA3);
        send_byte(8'hA4, 1'b0);
        expect_write("edge_a4", 2'd3, 8'hA4);
        step();
        chk1("edge_start", acc_start, 1'b1);

        // drops during WAIT, then saturation
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'hD0 + i), 1'b0);
            chk1($sformatf("drop%0d_we", i), mat_we, 1'b0);
        end
        chk("drop3_cnt", 32'(drop_cnt), 32'd3);
        for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        chk("drop_sat_cnt", 32'(drop_cnt), 32'd255);
        chk1("drop_sat_busy", busy, 1'b1);
        acc_done = 1'b1; acc_result = 32'h00C0FFEE;
        step();
        idle_inputs();
        chk("drop_gpio", gpio, 32'h00C0FFEE);

        // reset mid-frame aborts the frame
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) step();
        check_reset_values("midreset_hold");
        rst_n = 1'b1;
        step();
        send_byte(8'h09, 1'b0);
        expect_write("rel_b9", 2'd0, 8'h09);
        send_byte(8'h08, 1'b0);
        expect_write("rel_b8", 2'd1, 8'h08);
        send_byte(8'h07, 1'b0);
        expect_write("rel_b7", 2'd2, 8'h07);
        send_byte(8'h06, 1'b0);
        expect_write("rel_b6", 2'd3, 8'h06);
        step();
        chk1("rel_start", acc_start, 1'b1);

        // randomized frames against a frame-level reference model
        do_reset();
        begin
            int          frames;
            int          drop_exp;
            logic        err_exp;
            logic [31:0] gpio_exp;
            frames   = 30;
            drop_exp = 0;
            start_seen = 0;
            sb_en = 1'b1;
            for (int f = 0; f < frames; f++) begin
                logic seen;
                int   k;
                err_exp = 1'b0;
                for (int b = 0; b < N_ELEM; b++) begin
                    int          gap;
                    int          epos;
                    logic        inject;
                    logic [7:0]  d;
                    logic [AW-1:0] a;
                    gap    = (b == 0) ? $urandom_range(0, 5) : $urandom_range(0, IDLE_TMO - 2);
                    inject = (gap > 0) && ($urandom_range(0, 3) == 0);
                    epos   = (gap > 0) ? $urandom_range(0, gap - 1) : 0;
                    for (int g = 0; g < gap; g++) begin
                        if (inject && g == epos) send_byte(8'($urandom_range(0, 255)), 1'b1);
                        else step();
                    end
                    if (inject && b > 0) err_exp = 1'b1;
                    d = 8'($urandom_range(0, 255));
                    a = AW'(b);
                    exp_q.push_back({a, d});
                    send_byte(d, 1'b0);
                end
                seen = 1'b0;
                for (int i = 0; i < 8 && !seen; i++) begin
                    step();
                    if (acc_start) seen = 1'b1;
                end
                chk1($sformatf("rnd%0d_start", f), seen, 1'b1);
                k = $urandom_range(0, 3);
                for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
                drop_exp = (drop_exp + k > 255) ? 255 : drop_exp + k;
                repeat ($urandom_range(0, 20)) step();
                gpio_exp   = $urandom;
                acc_done   = 1'b1;
                acc_result = gpio_exp;
                step();
                idle_inputs();
                step();
                chk($sformatf("rnd%0d_gpio", f), gpio, gpio_exp);
                chk1($sformatf("rnd%0d_oe", f), gpio_oe, 1'b1);
                chk1($sformatf("rnd%0d_busy", f), busy, 1'b0);
                chk1($sformatf("rnd%0d_err", f), err, err_exp);
                chk($sformatf("rnd%0d_drop", f), 32'(drop_cnt), 32'(drop_exp));
            end
            step();
            sb_en = 1'b0;
            chk("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
            chk("rnd_start_count", 32'(start_seen), 32'(frames));
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/matrix_uart_sequencer.md
MATRIX_UART_SEQUENCER -- requirements
Module: matrix_uart_sequencer

Interface
REQ-001 SHALL provide parameter N_ELEM, default 4, number of matrix bytes per frame (power of 2, 2..16).
REQ-002 SHALL provide parameter IDLE_TMO, default 1024, inter-byte timeout in clocks during frame load.
REQ-003 SHALL provide parameter ACC_TMO, default 4096, maximum clocks waiting for accelerator done.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 sys_clk_i  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 rx_valid_i  in  1  one-cycle strobe: UART RX byte available.
REQ-008 rx_data_i  in  8  received byte, valid with rx_valid_i.
REQ-009 rx_err_i  in  1  framing error, qualifies rx_valid_i.
REQ-010 mat_we_o  out  1  matrix buffer write enable.
REQ-011 mat_addr_o  out  $clog2(N_ELEM)  matrix buffer write address.
REQ-012 mat_wdata_o  out  8  matrix buffer write data.
REQ-013 acc_start_o  out  1  one-cycle accelerator start pulse.
REQ-014 acc_done_i  in  1  one-cycle accelerator completion strobe.
REQ-015 acc_result_i  in  32  accelerator result, valid with acc_done_i.
REQ-016 gpio_o  out  32  latched result driven to GPIO pads.
REQ-017 gpio_oe_o  out  1  GPIO output enable.
REQ-018 busy_o  out  1  high in any state except IDLE.
REQ-019 err_o  out  1  sticky error flag.
REQ-020 drop_cnt_o  out  8  saturating count of bytes dropped while not loading.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, START, WAIT; registered outputs only.
REQ-022 IDLE: valid byte (rx_valid_i=1, rx_err_i=0) -> write at addr 0 next cycle, byte count=1, go LOAD (or START if N_ELEM reached).
REQ-023 Each valid byte SHALL produce mat_we_o=1 exactly one cycle later with mat_addr_o=count and mat_wdata_o=rx_data_i; latency 1 clock.
REQ-024 On the write of byte N_ELEM-1 the FSM SHALL enter START; acc_start_o SHALL pulse high for exactly one cycle on the following clock, then WAIT.
REQ-025 rx_valid_i with rx_err_i=1 SHALL be discarded (no write, count unchanged) and set err_o; FSM state unchanged.
REQ-026 LOAD: IDLE_TMO clocks with no valid byte -> set err_o, clear count, return IDLE; timer restarts on every valid byte.
REQ-027 rx_valid_i in START or WAIT SHALL be dropped and increment drop_cnt_o, saturating at 255.
REQ-028 WAIT: acc_done_i -> gpio_o<=acc_result_i next clock, gpio_oe_o<=1, return IDLE.
REQ-029 WAIT: ACC_TMO clocks without acc_done_i -> set err_o, gpio_o unchanged, return IDLE.
REQ-030 acc_done_i outside WAIT SHALL be ignored.
REQ-031 gpio_o SHALL hold the last result until the next acc_done_i in WAIT; gpio_oe_o stays 1 once set, until reset.
REQ-032 err_o SHALL clear when a valid byte is accepted in IDLE; a simultaneous new error in the same cycle SHALL win (err_o stays 1).
REQ-033 rx_valid_i in the same cycle as the LOAD timeout expiry SHALL be accepted as byte 0 of a new frame (timeout wins for count, byte restarts frame).

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE, count=0, timers=0, mat_we_o=0, mat_addr_o=0, mat_wdata_o=0, acc_start_o=0, gpio_o=0, gpio_oe_o=0, busy_o=0, err_o=0, drop_cnt_o=0.
REQ-035 Reset asserted mid-frame or in WAIT SHALL abort with no further writes or start pulse; first byte after release is addr 0.

Verification
REQ-036 Bytes 1,2,3,4 -> writes addr0..3 data 1..4, one acc_start_o pulse; acc_done_i with 0x0000000A -> gpio_o=0x0000000A, gpio_oe_o=1, busy_o=0.
REQ-037 Bytes 1,2 then IDLE_TMO silent clocks -> err_o=1, IDLE; next bytes 5,6,7,8 -> writes addr0..3, err_o=0 after byte 5.
REQ-038 Byte 0x33 with rx_err_i=1 mid-frame -> no write, err_o=1, next valid byte written at unchanged address.
REQ-039 Three bytes sent during WAIT -> drop_cnt_o=3, no mat_we_o; 300 dropped bytes -> drop_cnt_o=255.
REQ-040 No acc_done_i for ACC_TMO clocks -> err_o=1, IDLE, gpio_o keeps prior value.
REQ-041 rst_n low after byte 2 -> all outputs at reset values; frame 9,8,7,6 after release -> writes addr0..3.
